// File: rtl/onehot_seq_decoder.sv
// onehot_seq_decoder
// -----------------------------------------------------------------------------
// Registered one-hot decoder with a built-in scan sequencer. An IW-bit index
// is decoded into a 2**IW-wide one-hot select, either on demand through a
// valid/ready load port (direct mode) or by stepping through every output
// with a programmable dwell time (scan mode).
//
// Optional feature: define DCD_SCAN_MASK_EN to add the `mask` port. Scan then
// skips masked outputs. With it undefined the scan visits every index in order.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   en          block enable; 0 forces IDLE and clears the select
//   mode        0 = direct, 1 = scan
//   load_valid  load request, qualifies load_idx
//   load_ready  high in IDLE and DIRECT; a function of the state only
//   load_idx    index to decode, or scan start index
//   dwell       scan hold time; each output is held for dwell+1 cycles
//   mask        (DCD_SCAN_MASK_EN only) bit k=1 makes the scan skip output k
//   y           registered one-hot (or all-zero) select
//   idx         registered index currently decoded
//   y_valid     registered; high when y has exactly one bit set
//   wrap        registered one-cycle pulse when the scan steps back to a
//               numerically lower or equal index
// -----------------------------------------------------------------------------
module onehot_seq_decoder #(
    parameter int IW      = 4,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [IW-1:0]         load_idx,
    input  logic [DWELL_W-1:0]    dwell,
`ifdef DCD_SCAN_MASK_EN
    input  logic [(2**IW)-1:0]    mask,
`endif
    output logic [(2**IW)-1:0]    y,
    output logic [IW-1:0]         idx,
    output logic                  y_valid,
    output logic                  wrap
);

    localparam int N = 2 ** IW;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t               state_r;
    logic [DWELL_W-1:0]   cnt_r;

    logic [N-1:0]         scan_mask_s;
    logic                 scan_any_s;
    logic [IW-1:0]        start_raw_s;
    logic [IW-1:0]        start_idx_s;
    logic [IW-1:0]        next_idx_s;
    logic                 next_wrap_s;

    // One-hot encoding of an index.
    function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
        onehot = ONE << i;
    endfunction

    // First unmasked index at or after base, circularly. The loop runs from
    // the farthest offset down so the nearest hit is the last one written.
    // Returns base when every bit is masked; callers gate that case.
    function automatic logic [IW-1:0] find_free(input logic [IW-1:0] base,
                                                input logic [N-1:0]  msk);
        logic [IW-1:0] cand;
        find_free = base;
        for (int k = N - 1; k >= 0; k--) begin
            cand      = base + IW'(k);
            find_free = msk[cand] ? find_free : cand;
        end
    endfunction

`ifdef DCD_SCAN_MASK_EN
    assign scan_mask_s = mask;
`else
    assign scan_mask_s = {N{1'b0}};
`endif

    assign scan_any_s  = ~(&scan_mask_s);
    assign start_raw_s = load_valid ? load_idx : {IW{1'b0}};
    assign start_idx_s = scan_any_s ? find_free(start_raw_s, scan_mask_s) : start_raw_s;
    // Nearest unmasked index strictly above idx: search starts at idx+1 and
    // comes round to idx itself last, so a single-entry scan revisits idx.
    assign next_idx_s  = find_free(idx + IW'(1), scan_mask_s);
    assign next_wrap_s = (next_idx_s <= idx);

    assign load_ready  = (state_r == ST_IDLE) || (state_r == ST_DIRECT);

    // State machine, dwell counter and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {DWELL_W{1'b0}};
            y       <= {N{1'b0}};
            idx     <= {IW{1'b0}};
            y_valid <= 1'b0;
            wrap    <= 1'b0;
        end else if (!en) begin
            // Disable wins over everything; idx deliberately holds.
            state_r <= ST_IDLE;
            y       <= {N{1'b0}};
            y_valid <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wrap <= 1'b0;
                    if (mode) begin
                        state_r <= ST_SCAN;
                        cnt_r   <= dwell;
                        idx     <= start_idx_s;
                        y       <= scan_any_s ? onehot(start_idx_s) : {N{1'b0}};
                        y_valid <= scan_any_s;
                    end else if (load_valid) begin
                        state_r <= ST_DIRECT;
                        idx     <= load_idx;
                        y       <= onehot(load_idx);
                        y_valid <= 1'b1;
                    end else begin
                        y       <= {N{1'b0}};
                        y_valid <= 1'b0;
                    end
                end
                ST_DIRECT: begin
                    wrap <= 1'b0;
                    if (mode) begin
                        // Scan continues from the displayed index; any load
                        // presented on this cycle is dropped.
                        state_r <= ST_SCAN;
                        cnt_r   <= dwell;
                    end else if (load_valid) begin
                        idx     <= load_idx;
                        y       <= onehot(load_idx);
                        y_valid <= 1'b1;
                    end else begin
                        y       <= onehot(idx);
                        y_valid <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (!mode) begin
                        // Direct mode ignores the mask, so the held index is
                        // shown even if the scan had it blanked.
                        state_r <= ST_DIRECT;
                        y       <= onehot(idx);
                        y_valid <= 1'b1;
                        wrap    <= 1'b0;
                    end else if (cnt_r != {DWELL_W{1'b0}}) begin
                        cnt_r <= cnt_r - DWELL_W'(1);
                        wrap  <= 1'b0;
                    end else begin
                        cnt_r <= dwell;
                        if (scan_any_s) begin
                            idx     <= next_idx_s;
                            y       <= onehot(next_idx_s);
                            y_valid <= 1'b1;
                            wrap    <= next_wrap_s;
                        end else begin
                            y       <= {N{1'b0}};
                            y_valid <= 1'b0;
                            wrap    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    y       <= {N{1'b0}};
                    y_valid <= 1'b0;
                    wrap    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_seq_decoder.sv
// Self-checking bench for onehot_seq_decoder: a behavioural model checks the
// IW=4 instance every cycle; directed literal expectations pin the model and
// cover the IW=2 and IW=6 builds.
module tb_onehot_seq_decoder;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        mode = 1'b0;
    logic        load_valid = 1'b0;
    logic [3:0]  load_idx = 4'd0;
    logic [7:0]  dwell = 8'd0;
    logic [15:0] mask_sig = 16'h0000;
    logic        load_ready;
    logic [15:0] y;
    logic [3:0]  idx;
    logic        y_valid;
    logic        wrap;

    logic        en2 = 1'b0;
    logic [1:0]  load_idx2 = 2'd0;
    logic        load_ready2;
    logic [3:0]  y2;
    logic [1:0]  idx2;
    logic        y_valid2;
    logic        wrap2;

    logic        en6 = 1'b0;
    logic [5:0]  load_idx6 = 6'd0;
    logic        load_ready6;
    logic [63:0] y6;
    logic [5:0]  idx6;
    logic        y_valid6;
    logic        wrap6;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    onehot_seq_decoder #(.IW(4), .DWELL_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_idx(load_idx), .dwell(dwell),
`ifdef DCD_SCAN_MASK_EN
        .mask(mask_sig),
`endif
        .y(y), .idx(idx), .y_valid(y_valid), .wrap(wrap)
    );

    onehot_seq_decoder #(.IW(2), .DWELL_W(8)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .mode(mode),
        .load_valid(load_valid), .load_ready(load_ready2),
        .load_idx(load_idx2), .dwell(dwell),
`ifdef DCD_SCAN_MASK_EN
        .mask(4'h0),
`endif
        .y(y2), .idx(idx2), .y_valid(y_valid2), .wrap(wrap2)
    );

    onehot_seq_decoder #(.IW(6), .DWELL_W(8)) dut6 (
        .clk(clk), .rst(rst), .en(en6), .mode(mode),
        .load_valid(load_valid), .load_ready(load_ready6),
        .load_idx(load_idx6), .dwell(dwell),
`ifdef DCD_SCAN_MASK_EN
        .mask(64'h0),
`endif
        .y(y6), .idx(idx6), .y_valid(y_valid6), .wrap(wrap6)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode of operation, shown index, whether a select is
    // shown, and how long the current index has been on display.
    int m_st = 0;          // 0 idle, 1 direct, 2 scan
    int m_idx = 0;
    bit m_valid = 1'b0;
    bit m_wrap = 1'b0;
    int m_age = 0;         // cycles the current index has been shown
    int m_period = 1;      // cycles it must be shown (dwell+1 at its start)
    int m_free;

    // First index at or after `from` (circularly) the scan may visit, -1 if none.
    function automatic int first_free(input int from);
        for (int k = 0; k < N; k++) begin
            if (!mask_sig[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = 0; m_idx = 0; m_valid = 1'b0; m_wrap = 1'b0;
        end else if (!en) begin
            m_st = 0; m_valid = 1'b0; m_wrap = 1'b0;
        end else if (m_st == 0) begin
            m_wrap = 1'b0;
            if (mode) begin
                m_st = 2; m_age = 1; m_period = int'(dwell) + 1;
                m_free = first_free(load_valid ? int'(load_idx) : 0);
                m_valid = (m_free >= 0);
                m_idx = (m_free >= 0) ? m_free : (load_valid ? int'(load_idx) : 0);
            end else if (load_valid) begin
                m_st = 1; m_idx = int'(load_idx); m_valid = 1'b1;
            end
        end else if (m_st == 1) begin
            m_wrap = 1'b0;
            if (mode) begin
                m_st = 2; m_age = 1; m_period = int'(dwell) + 1;
            end else if (load_valid) begin
                m_idx = int'(load_idx);
            end
        end else begin
            if (!mode) begin
                m_st = 1; m_valid = 1'b1; m_wrap = 1'b0;
            end else if (m_age < m_period) begin
                m_age++; m_wrap = 1'b0;
            end else begin
                m_age = 1; m_period = int'(dwell) + 1;
                m_free = first_free((m_idx + 1) % N);
                if (m_free < 0) begin
                    m_valid = 1'b0; m_wrap = 1'b0;
                end else begin
                    m_wrap = (m_free <= m_idx); m_idx = m_free; m_valid = 1'b1;
                end
            end
        end
        #1;
        check("model_y", 64'(y), m_valid ? (64'd1 << m_idx) : 64'd0);
        check("model_idx", 64'(idx), 64'(m_idx));
        check("model_y_valid", 64'(y_valid), 64'(m_valid));
        check("model_wrap", 64'(wrap), 64'(m_wrap));
        check("model_load_ready", 64'(load_ready), 64'(m_st != 2));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        check("reset_y", 64'(y), 64'h0);
        check("reset_idx", 64'(idx), 64'h0);
        check("reset_valid_wrap", {62'd0, y_valid, wrap}, 64'h0);
        check("reset_ready", 64'(load_ready), 64'h1);

        // Direct loads
        en = 1'b1; mode = 1'b0; load_valid = 1'b1; load_idx = 4'd9;
        tick();
        check("direct9_y", 64'(y), 64'h0200);
        check("direct9_idx", 64'(idx), 64'd9);
        check("direct9_valid", 64'(y_valid), 64'h1);
        load_idx = 4'd15;
        tick();
        check("direct15_y", 64'(y), 64'h8000);
        load_valid = 1'b0;
        tick();
        check("direct_hold_y", 64'(y), 64'h8000);

        // Asynchronous reset mid-operation
        rst = 1'b1;
        #1;
        check("async_rst_y", 64'(y), 64'h0);
        check("async_rst_valid", 64'(y_valid), 64'h0);
        check("async_rst_idx", 64'(idx), 64'h0);
        tick();
        rst = 1'b0;

        // Full-rate scan
        mode = 1'b1; dwell = 8'd0;
        tick();
        check("scan0_y", 64'(y), 64'h0001);
        check("scan0_ready", 64'(load_ready), 64'h0);
        for (int k = 1; k < 16; k++) begin
            tick();
            check("scan_y", 64'(y), 64'd1 << k);
            check("scan_wrap", 64'(wrap), 64'h0);
        end
        tick();
        check("scan_wrap_y", 64'(y), 64'h0001);
        check("scan_wrap_pulse", 64'(wrap), 64'h1);
        tick();
        check("scan_wrap_drop", 64'(wrap), 64'h0);

        // Dwell of 2 starting at index 14
        en = 1'b0;
        tick();
        check("dis_y", 64'(y), 64'h0);
        en = 1'b1; dwell = 8'd2; load_valid = 1'b1; load_idx = 4'd14;
        tick();
        load_valid = 1'b0;
        check("dwell14_a", 64'(y), 64'h4000);
        tick(); check("dwell14_b", 64'(y), 64'h4000);
        tick(); check("dwell14_c", 64'(y), 64'h4000);
        tick(); check("dwell15_a", 64'(y), 64'h8000);
        tick(); tick(); check("dwell15_c", 64'(y), 64'h8000);
        tick();
        check("dwell_wrap_y", 64'(y), 64'h0001);
        check("dwell_wrap", 64'(wrap), 64'h1);
        // Changing dwell mid-hold only applies at the next reload
        dwell = 8'd0;
        tick(); check("midhold_b", 64'(y), 64'h0001);
        tick(); check("midhold_c", 64'(y), 64'h0001);
        tick(); check("reload_1", 64'(y), 64'h0002);
        tick(); check("reload_2", 64'(y), 64'h0004);
        tick(); tick(); tick();
        check("scan_at_5", 64'(y), 64'h0020);

        // Mode and enable switching
        mode = 1'b0;
        tick();
        check("to_direct_y", 64'(y), 64'h0020);
        check("to_direct_ready", 64'(load_ready), 64'h1);
        tick();
        check("direct_hold5", 64'(y), 64'h0020);
        en = 1'b0;
        tick();
        check("en0_y", 64'(y), 64'h0);
        check("en0_valid", 64'(y_valid), 64'h0);
        check("en0_idx_hold", 64'(idx), 64'd5);
        en = 1'b1;
        tick();
        check("idle_y", 64'(y), 64'h0);
        check("idle_ready", 64'(load_ready), 64'h1);
        load_valid = 1'b1; load_idx = 4'd3;
        tick();
        check("idle_load3", 64'(y), 64'h0008);
        mode = 1'b1; load_idx = 4'd10;
        tick();
        check("to_scan_ignore_load", 64'(y), 64'h0008);
        check("to_scan_ready", 64'(load_ready), 64'h0);
        load_valid = 1'b0;
        tick();
        check("to_scan_step", 64'(y), 64'h0010);
        en = 1'b0;
        tick();

        // IW=2 and IW=6 builds: direct load of the top index, then a full sweep
        mode = 1'b0; load_valid = 1'b1; en2 = 1'b1; en6 = 1'b1;
        load_idx2 = 2'd3; load_idx6 = 6'd63;
        tick();
        check("iw2_top_y", 64'(y2), 64'h8);
        check("iw2_top_idx", 64'(idx2), 64'd3);
        check("iw6_top_y", y6, 64'h8000_0000_0000_0000);
        check("iw6_top_idx", 64'(idx6), 64'd63);
        en2 = 1'b0; en6 = 1'b0; load_valid = 1'b0;
        tick();
        check("iw6_dis_valid", 64'(y_valid6), 64'h0);
        mode = 1'b1; dwell = 8'd0; en2 = 1'b1; en6 = 1'b1;
        for (int k = 0; k <= 64; k++) begin
            tick();
            check("iw2_scan_y", 64'(y2), 64'd1 << (k % 4));
            check("iw2_scan_wrap", 64'(wrap2), 64'((k > 0) && (k % 4 == 0)));
            check("iw6_scan_y", y6, 64'd1 << (k % 64));
            check("iw6_scan_wrap", 64'(wrap6), 64'(k == 64));
        end
        check("iw2_scan_ready", 64'(load_ready2), 64'h0);
        check("iw6_scan_ready", 64'(load_ready6), 64'h0);
        en2 = 1'b0; en6 = 1'b0;
        tick();

`ifdef DCD_SCAN_MASK_EN
        // Masked scan over indices 0..3, then everything masked, then resume
        mask_sig = 16'hFFF0; en = 1'b1; mode = 1'b1; dwell = 8'd0;
        tick(); check("mask_y0", 64'(y), 64'h1);
        tick(); check("mask_y1", 64'(y), 64'h2);
        tick(); check("mask_y2", 64'(y), 64'h4);
        tick(); check("mask_y3", 64'(y), 64'h8);
        tick();
        check("mask_wrap_y", 64'(y), 64'h1);
        check("mask_wrap", 64'(wrap), 64'h1);
        mask_sig = 16'hFFFF;
        tick();
        check("allmask_y", 64'(y), 64'h0);
        check("allmask_valid", 64'(y_valid), 64'h0);
        tick();
        mask_sig = 16'h0000;
        tick();
        check("unmask_y", 64'(y), 64'h2);
        check("unmask_valid", 64'(y_valid), 64'h1);
        en = 1'b0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
